commit_stage: RTL and testbench
===============================

COMMIT_STAGE -- requirements
Module: commit_stage

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port nrst, input, 1 bit: reset, synchronous and active-low.
REQ-003 The module SHALL have inputs valid5 (1 bit), we5 (1), rd5 (5), result5 (32) and pc5 (32): the execute-stage instruction, its regfile write request and its PC.
REQ-004 The module SHALL have inputs csr_we5 (1), csr_addr5 (12) and csr_wdata5 (32): the CSR write request from the execute-stage csr unit.
REQ-005 The module SHALL have 1-bit exception inputs instruction_addr_misaligned5, illegal_instr5, ecall5, ebreak5, mret5, sret5 and uret5.
REQ-006 The module SHALL have inputs current_mode (2 bits), m_timer, s_timer, u_timer, m_tie, s_tie and u_tie (1 bit each), all from csr_regfile.
REQ-007 The module SHALL have input stall_mem, 1 bit: memory stall; the execute stage holds its instruction while it is high.
REQ-008 The module SHALL have outputs we6 (1), rdaddr6 (5) and wb6 (32): the regfile write port.
REQ-009 The module SHALL have outputs csr_we6 (1), csr_wb_addr (12) and csr_wb (32): the csr_regfile write port.
REQ-010 The module SHALL have outputs exception_pending (1), cause (32), pc_exc (32), m_ret, s_ret and u_ret (1 each): trap and return controls to csr_regfile.
REQ-011 The module SHALL have outputs m_interrupt, s_interrupt and u_interrupt (1 each): the interrupt-taken pulses.
REQ-012 The module SHALL have output exception, 1 bit: flush request to the scoreboard and the front end.

Function
REQ-013 All outputs SHALL be registered, with a latency of exactly one cycle from the stage-5 inputs.
REQ-014 An instruction SHALL be accepted when valid5=1, stall_mem=0 and state=RUN; otherwise a bubble SHALL be loaded (all write enables and pulses 0).
REQ-015 An instruction held under stall_mem SHALL write the regfile and CSRs exactly once, in the cycle after stall_mem falls.
REQ-016 For an accepted instruction with no trap and no return, we6 SHALL equal we5 AND (rd5 != 0), with rdaddr6=rd5, wb6=result5, csr_we6=csr_we5, csr_wb_addr=csr_addr5 and csr_wb=csr_wdata5.
REQ-017 Synchronous trap priority SHALL be illegal (cause 2) > instruction misaligned (0) > ebreak (3) > ecall.
REQ-018 The ecall cause SHALL be 8 in U mode, 9 in S mode and 11 in M mode, taken from current_mode (0, 1, 3).
REQ-019 An interrupt SHALL be taken when any pair x_timer AND x_tie is set on an accepted instruction, and SHALL outrank all synchronous traps.
REQ-020 The interrupt priority SHALL be M > S > U, with cause 0x80000007, 0x80000005 or 0x80000004 respectively, and the matching x_interrupt output pulsed for 1 cycle.
REQ-021 On any trap the module SHALL set we6=0, csr_we6=0, exception_pending=1 for 1 cycle, pc_exc=pc5 and cause as above.
REQ-022 An accepted xret with no trap SHALL pulse exactly one of m_ret, s_ret or u_ret for 1 cycle, and SHALL write neither the regfile nor the CSRs.
REQ-023 The FSM SHALL have states RUN, FLUSH1 and FLUSH2.
REQ-024 The FSM SHALL move from RUN to FLUSH1 on a trap or xret, from FLUSH1 to FLUSH2 unconditionally, and from FLUSH2 to RUN unconditionally.
REQ-025 exception SHALL be 1 in the trap/xret commit cycle and throughout FLUSH1 and FLUSH2 (3 cycles total); all inputs SHALL be discarded while in FLUSH1 or FLUSH2.
REQ-026 A trap or xret arriving together with stall_mem=1 SHALL wait until it is accepted.
REQ-027 When interrupt and xret are simultaneous, the interrupt SHALL win and no x_ret SHALL pulse.

Reset
REQ-028 While nrst=0 at a clock edge, the state SHALL become RUN and every output SHALL be 0.
REQ-029 A reset during FLUSH1 or FLUSH2 SHALL abort the flush, with no further exception pulse.

Structure
REQ-030 The cause codes, the mode encodings and the FSM state enum SHALL be defined in the shared package core_pkg.
REQ-031 The trap priority and cause encoder SHALL be the sub-module trap_encoder, which is combinational.

Verification
REQ-032 The bench SHALL cover valid5=1, we5=1, rd5=5, result5=0xDEADBEEF -> next cycle we6=1, rdaddr6=5, wb6=0xDEADBEEF; a repeat with rd5=0 -> we6=0.
REQ-033 The bench SHALL cover illegal_instr5=1 with ecall5=1, pc5=0x100 -> exception_pending=1, cause=2, pc_exc=0x100, we6=0, exception high for 3 cycles, and the next two valid inputs dropped.
REQ-034 The bench SHALL cover ecall5=1 with current_mode=0 -> cause=8, and with current_mode=3 -> cause=11.
REQ-035 The bench SHALL cover m_timer=m_tie=1 with mret5=1 -> cause=0x80000007, m_interrupt=1 and m_ret=0.
REQ-036 The bench SHALL cover stall_mem=1 for 4 cycles with we5=1 held -> we6=0 throughout, then exactly one we6=1 pulse after release.
REQ-037 The bench SHALL cover nrst=0 asserted in FLUSH1 -> all outputs 0 next cycle and the state RUN.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the commit stage: trap cause codes, privilege modes,
// commit FSM states and the registered stage-6 output bundle.
package core_pkg;

  localparam logic [1:0] MODE_U = 2'd0;
  localparam logic [1:0] MODE_S = 2'd1;
  localparam logic [1:0] MODE_M = 2'd3;

  localparam logic [31:0] CAUSE_MISALIGNED  = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK      = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_U     = 32'd8;
  localparam logic [31:0] CAUSE_ECALL_S     = 32'd9;
  localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
  localparam logic [31:0] CAUSE_M_TIMER_INT = 32'h8000_0007;
  localparam logic [31:0] CAUSE_S_TIMER_INT = 32'h8000_0005;
  localparam logic [31:0] CAUSE_U_TIMER_INT = 32'h8000_0004;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH1 = 2'd1,
    FLUSH2 = 2'd2
  } commit_state_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rdaddr;
    logic [31:0] wb;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wb;
    logic        exc_pending;
    logic [31:0] cause;
    logic [31:0] pc_exc;
    logic        m_ret;
    logic        s_ret;
    logic        u_ret;
    logic        m_int;
    logic        s_int;
    logic        u_int;
    logic        flush;
  } commit_out_t;

  // The reserved mode encoding falls back to the machine-mode cause.
  function automatic logic [31:0] ecall_cause(input logic [1:0] mode);
    case (mode)
      MODE_U:  return CAUSE_ECALL_U;
      MODE_S:  return CAUSE_ECALL_S;
      MODE_M:  return CAUSE_ECALL_M;
      default: return CAUSE_ECALL_M;
    endcase
  endfunction

endpackage

// File: rtl/trap_encoder.sv
// Combinational trap prioritiser: timer interrupts (M > S > U) outrank the
// synchronous traps (illegal > misaligned > ebreak > ecall).
module trap_encoder
  import core_pkg::*;
(
  input  logic        i_illegal,
  input  logic        i_misaligned,
  input  logic        i_ebreak,
  input  logic        i_ecall,
  input  logic [1:0]  i_mode,
  input  logic        i_m_irq,
  input  logic        i_s_irq,
  input  logic        i_u_irq,
  output logic        o_trap,
  output logic [31:0] o_cause,
  output logic        o_m_int,
  output logic        o_s_int,
  output logic        o_u_int
);

  always_comb begin
    o_trap  = 1'b1;
    o_cause = '0;
    o_m_int = 1'b0;
    o_s_int = 1'b0;
    o_u_int = 1'b0;
    if (i_m_irq) begin
      o_cause = CAUSE_M_TIMER_INT;
      o_m_int = 1'b1;
    end else if (i_s_irq) begin
      o_cause = CAUSE_S_TIMER_INT;
      o_s_int = 1'b1;
    end else if (i_u_irq) begin
      o_cause = CAUSE_U_TIMER_INT;
      o_u_int = 1'b1;
    end else if (i_illegal) begin
      o_cause = CAUSE_ILLEGAL;
    end else if (i_misaligned) begin
      o_cause = CAUSE_MISALIGNED;
    end else if (i_ebreak) begin
      o_cause = CAUSE_EBREAK;
    end else if (i_ecall) begin
      o_cause = ecall_cause(i_mode);
    end else begin
      o_trap = 1'b0;
    end
  end

endmodule

// File: rtl/commit_stage.sv
// Stage-6 commit: registers regfile/CSR writes, raises traps and xret pulses,
// and holds the pipeline flush request for three cycles after a redirect.
module commit_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid5,
  input  logic        we5,
  input  logic [4:0]  rd5,
  input  logic [31:0] result5,
  input  logic [31:0] pc5,
  input  logic        csr_we5,
  input  logic [11:0] csr_addr5,
  input  logic [31:0] csr_wdata5,
  input  logic        instruction_addr_misaligned5,
  input  logic        illegal_instr5,
  input  logic        ecall5,
  input  logic        ebreak5,
  input  logic        mret5,
  input  logic        sret5,
  input  logic        uret5,
  input  logic [1:0]  current_mode,
  input  logic        m_timer,
  input  logic        s_timer,
  input  logic        u_timer,
  input  logic        m_tie,
  input  logic        s_tie,
  input  logic        u_tie,
  input  logic        stall_mem,
  output logic        we6,
  output logic [4:0]  rdaddr6,
  output logic [31:0] wb6,
  output logic        csr_we6,
  output logic [11:0] csr_wb_addr,
  output logic [31:0] csr_wb,
  output logic        exception_pending,
  output logic [31:0] cause,
  output logic [31:0] pc_exc,
  output logic        m_ret,
  output logic        s_ret,
  output logic        u_ret,
  output logic        m_interrupt,
  output logic        s_interrupt,
  output logic        u_interrupt,
  output logic        exception
);

  commit_state_t r_state, w_state_nxt;
  commit_out_t   r_out, w_out_nxt;

  logic        w_accept;
  logic        w_xret;
  logic        w_trap;
  logic [31:0] w_cause;
  logic        w_m_int, w_s_int, w_u_int;

  assign w_accept = valid5 && !stall_mem && (r_state == RUN);
  assign w_xret   = mret5 || sret5 || uret5;

  trap_encoder u_trap_encoder (
    .i_illegal    (illegal_instr5),
    .i_misaligned (instruction_addr_misaligned5),
    .i_ebreak     (ebreak5),
    .i_ecall      (ecall5),
    .i_mode       (current_mode),
    .i_m_irq      (m_timer && m_tie),
    .i_s_irq      (s_timer && s_tie),
    .i_u_irq      (u_timer && u_tie),
    .o_trap       (w_trap),
    .o_cause      (w_cause),
    .o_m_int      (w_m_int),
    .o_s_int      (w_s_int),
    .o_u_int      (w_u_int)
  );

  always_comb begin
    w_out_nxt   = '0;
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_accept) begin
          w_out_nxt.rdaddr   = rd5;
          w_out_nxt.wb       = result5;
          w_out_nxt.csr_addr = csr_addr5;
          w_out_nxt.csr_wb   = csr_wdata5;
          if (w_trap) begin
            w_out_nxt.exc_pending = 1'b1;
            w_out_nxt.cause       = w_cause;
            w_out_nxt.pc_exc      = pc5;
            w_out_nxt.m_int       = w_m_int;
            w_out_nxt.s_int       = w_s_int;
            w_out_nxt.u_int       = w_u_int;
            w_out_nxt.flush       = 1'b1;
            w_state_nxt           = FLUSH1;
          end else if (w_xret) begin
            // Only the highest-privilege return fires if several are raised.
            w_out_nxt.m_ret = mret5;
            w_out_nxt.s_ret = !mret5 && sret5;
            w_out_nxt.u_ret = !mret5 && !sret5 && uret5;
            w_out_nxt.flush = 1'b1;
            w_state_nxt     = FLUSH1;
          end else begin
            w_out_nxt.we     = we5 && (rd5 != 5'd0);
            w_out_nxt.csr_we = csr_we5;
          end
        end
      end
      FLUSH1: begin
        w_out_nxt.flush = 1'b1;
        w_state_nxt     = FLUSH2;
      end
      FLUSH2: begin
        w_out_nxt.flush = 1'b1;
        w_state_nxt     = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= RUN;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign we6               = r_out.we;
  assign rdaddr6           = r_out.rdaddr;
  assign wb6               = r_out.wb;
  assign csr_we6           = r_out.csr_we;
  assign csr_wb_addr       = r_out.csr_addr;
  assign csr_wb            = r_out.csr_wb;
  assign exception_pending = r_out.exc_pending;
  assign cause             = r_out.cause;
  assign pc_exc            = r_out.pc_exc;
  assign m_ret             = r_out.m_ret;
  assign s_ret             = r_out.s_ret;
  assign u_ret             = r_out.u_ret;
  assign m_interrupt       = r_out.m_int;
  assign s_interrupt       = r_out.s_int;
  assign u_interrupt       = r_out.u_int;
  assign exception         = r_out.flush;

endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_commit_stage;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid5, we5, csr_we5, stall_mem;
  logic [4:0]  rd5;
  logic [31:0] result5, pc5, csr_wdata5;
  logic [11:0] csr_addr5;
  logic        instruction_addr_misaligned5, illegal_instr5, ecall5, ebreak5;
  logic        mret5, sret5, uret5;
  logic [1:0]  current_mode;
  logic        m_timer, s_timer, u_timer, m_tie, s_tie, u_tie;

  logic        we6, csr_we6, exception_pending, exception;
  logic [4:0]  rdaddr6;
  logic [31:0] wb6, csr_wb, cause, pc_exc;
  logic [11:0] csr_wb_addr;
  logic        m_ret, s_ret, u_ret, m_interrupt, s_interrupt, u_interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state and expected outputs for the cycle after the edge
  int          m_flush_left = 0;
  logic        e_we, e_csr_we, e_pend, e_exc;
  logic [4:0]  e_rd;
  logic [31:0] e_wb, e_csr_wb, e_cause, e_pc;
  logic [11:0] e_csr_addr;
  logic        e_mret, e_sret, e_uret, e_mint, e_sint, e_uint;

  always #5 clk = ~clk;

  commit_stage dut (
    .clk(clk), .nrst(nrst), .valid5(valid5), .we5(we5), .rd5(rd5),
    .result5(result5), .pc5(pc5), .csr_we5(csr_we5), .csr_addr5(csr_addr5),
    .csr_wdata5(csr_wdata5),
    .instruction_addr_misaligned5(instruction_addr_misaligned5),
    .illegal_instr5(illegal_instr5), .ecall5(ecall5), .ebreak5(ebreak5),
    .mret5(mret5), .sret5(sret5), .uret5(uret5), .current_mode(current_mode),
    .m_timer(m_timer), .s_timer(s_timer), .u_timer(u_timer),
    .m_tie(m_tie), .s_tie(s_tie), .u_tie(u_tie), .stall_mem(stall_mem),
    .we6(we6), .rdaddr6(rdaddr6), .wb6(wb6), .csr_we6(csr_we6),
    .csr_wb_addr(csr_wb_addr), .csr_wb(csr_wb),
    .exception_pending(exception_pending), .cause(cause), .pc_exc(pc_exc),
    .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret),
    .m_interrupt(m_interrupt), .s_interrupt(s_interrupt),
    .u_interrupt(u_interrupt), .exception(exception)
  );

  // Behavioural view: a flush is a count of cycles to ignore, a trap is the
  // first hit in a priority list, and an ecall cause is 8 plus the mode.
  task automatic model_edge();
    {e_we, e_csr_we, e_pend, e_exc, e_mret, e_sret, e_uret, e_mint, e_sint, e_uint} = '0;
    e_rd = '0; e_wb = '0; e_csr_addr = '0; e_csr_wb = '0; e_cause = '0; e_pc = '0;
    if (!nrst) begin
      m_flush_left = 0;
    end else if (m_flush_left > 0) begin
      e_exc = 1'b1;
      m_flush_left--;
    end else if (valid5 && !stall_mem) begin
      if (m_timer && m_tie) begin e_pend = 1; e_mint = 1; e_cause = 32'h8000_0007; end
      else if (s_timer && s_tie) begin e_pend = 1; e_sint = 1; e_cause = 32'h8000_0005; end
      else if (u_timer && u_tie) begin e_pend = 1; e_uint = 1; e_cause = 32'h8000_0004; end
      else if (illegal_instr5) begin e_pend = 1; e_cause = 2; end
      else if (instruction_addr_misaligned5) begin e_pend = 1; e_cause = 0; end
      else if (ebreak5) begin e_pend = 1; e_cause = 3; end
      else if (ecall5) begin e_pend = 1; e_cause = 32'(8 + int'(current_mode)); end
      if (e_pend) begin
        e_pc = pc5; e_exc = 1; m_flush_left = 2;
      end else if (mret5 || sret5 || uret5) begin
        e_mret = mret5; e_sret = sret5; e_uret = uret5;
        e_exc = 1; m_flush_left = 2;
      end else begin
        e_we = we5 && (rd5 != 0); e_rd = e_we ? rd5 : 5'd0; e_wb = e_we ? result5 : 32'd0;
        e_csr_we = csr_we5;
        e_csr_addr = csr_we5 ? csr_addr5 : 12'd0;
        e_csr_wb   = csr_we5 ? csr_wdata5 : 32'd0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // data fields are only meaningful when their enable is expected high
  function automatic logic [154:0] act_vec();
    return {we6, e_we ? rdaddr6 : 5'd0, e_we ? wb6 : 32'd0,
            csr_we6, e_csr_we ? csr_wb_addr : 12'd0, e_csr_we ? csr_wb : 32'd0,
            exception_pending, e_pend ? cause : 32'd0, e_pend ? pc_exc : 32'd0,
            m_ret, s_ret, u_ret, m_interrupt, s_interrupt, u_interrupt, exception};
  endfunction

  function automatic logic [154:0] exp_vec();
    return {e_we, e_rd, e_wb, e_csr_we, e_csr_addr, e_csr_wb, e_pend, e_cause, e_pc,
            e_mret, e_sret, e_uret, e_mint, e_sint, e_uint, e_exc};
  endfunction

  task automatic clear_inputs();
    nrst = 1; valid5 = 0; we5 = 0; rd5 = 0; result5 = 0; pc5 = 0;
    csr_we5 = 0; csr_addr5 = 0; csr_wdata5 = 0; stall_mem = 0;
    instruction_addr_misaligned5 = 0; illegal_instr5 = 0; ecall5 = 0; ebreak5 = 0;
    mret5 = 0; sret5 = 0; uret5 = 0; current_mode = 2'd3;
    m_timer = 0; s_timer = 0; u_timer = 0; m_tie = 0; s_tie = 0; u_tie = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    nrst = 0; valid5 = 1; we5 = 1; rd5 = 5'd3; result5 = 32'h1234; illegal_instr5 = 1;
    tick(); tick();
    n_checks++;
    if ({we6, rdaddr6, wb6, csr_we6, csr_wb_addr, csr_wb, exception_pending, cause, pc_exc,
         m_ret, s_ret, u_ret, m_interrupt, s_interrupt, u_interrupt, exception} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we6=%b exc=%b pend=%b wb6=%h, required all zero",
               we6, exception, exception_pending, wb6);
    end
    clear_inputs();
  endtask

  task automatic test_writeback();
    clear_inputs();
    valid5 = 1; we5 = 1; rd5 = 5'd5; result5 = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({we6, rdaddr6, wb6} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL writeback: got we6=%b rd=%0d wb=%h, required 1/5/deadbeef", we6, rdaddr6, wb6);
    end
    rd5 = 5'd0;
    tick();
    n_checks++;
    if (we6 !== 1'b0) begin
      n_fail++;
      $display("FAIL writeback_x0: got we6=%b, required 0", we6);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_illegal_flush();
    clear_inputs();
    valid5 = 1; illegal_instr5 = 1; ecall5 = 1; pc5 = 32'h100; we5 = 1; rd5 = 5'd3;
    tick();
    n_checks++;
    if ({exception_pending, cause, pc_exc, we6, exception} !== {1'b1, 32'd2, 32'h100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_trap: got pend=%b cause=%h pc=%h we6=%b exc=%b, required 1/2/100/0/1",
               exception_pending, cause, pc_exc, we6, exception);
    end
    illegal_instr5 = 0; ecall5 = 0; rd5 = 5'd7; result5 = 32'h77;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({exception, we6, exception_pending} !== 3'b100) begin
        n_fail++;
        $display("FAIL flush_drop%0d: got exc=%b we6=%b pend=%b, required 1/0/0",
                 i, exception, we6, exception_pending);
      end
    end
    tick();
    n_checks++;
    if ({exception, we6, rdaddr6} !== {1'b0, 1'b1, 5'd7}) begin
      n_fail++;
      $display("FAIL flush_end: got exc=%b we6=%b rd=%0d, required 0/1/7", exception, we6, rdaddr6);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_ecall_modes();
    logic [1:0]  modes  [3] = '{2'd0, 2'd1, 2'd3};
    logic [31:0] causes [3] = '{32'd8, 32'd9, 32'd11};
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      valid5 = 1; ecall5 = 1; current_mode = modes[i]; pc5 = 32'h200 + 32'(i * 4);
      tick();
      n_checks++;
      if ({exception_pending, cause} !== {1'b1, causes[i]}) begin
        n_fail++;
        $display("FAIL ecall_mode%0d: got pend=%b cause=%0d, required 1/%0d",
                 modes[i], exception_pending, cause, causes[i]);
      end
      clear_inputs();
      tick(); tick();
    end
  endtask

  task automatic test_irq_vs_mret();
    clear_inputs();
    valid5 = 1; mret5 = 1; m_timer = 1; m_tie = 1; s_timer = 1; s_tie = 1; pc5 = 32'h300;
    tick();
    n_checks++;
    if ({cause, m_interrupt, s_interrupt, m_ret, exception_pending} !== {32'h8000_0007, 4'b1001}) begin
      n_fail++;
      $display("FAIL irq_over_mret: got cause=%h mint=%b sint=%b mret=%b pend=%b, required 80000007/1/0/0/1",
               cause, m_interrupt, s_interrupt, m_ret, exception_pending);
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_stall();
    int pulses = 0;
    clear_inputs();
    valid5 = 1; we5 = 1; rd5 = 5'd9; result5 = 32'hCAFE0009; stall_mem = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (we6 !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got we6=%b, required 0", i, we6);
      end
    end
    stall_mem = 0;
    tick();
    if (we6 === 1'b1 && wb6 === 32'hCAFE0009) pulses++;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (we6 !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL stall_release: got %0d write pulses, required 1", pulses);
    end
  endtask

  task automatic test_reset_in_flush();
    clear_inputs();
    valid5 = 1; ebreak5 = 1; we5 = 1; rd5 = 5'd2;
    tick();
    clear_inputs();
    nrst = 0;
    tick();
    n_checks++;
    if ({we6, csr_we6, exception_pending, cause, pc_exc, m_ret, s_ret, u_ret,
         m_interrupt, s_interrupt, u_interrupt, exception, rdaddr6, wb6} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_flush: got exc=%b pend=%b cause=%h, required all zero",
               exception, exception_pending, cause);
    end
    nrst = 1; valid5 = 1; we5 = 1; rd5 = 5'd4; result5 = 32'h44;
    tick();
    n_checks++;
    if ({we6, exception} !== 2'b10) begin
      n_fail++;
      $display("FAIL run_after_reset: got we6=%b exc=%b, required 1/0", we6, exception);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int cyc = 0; cyc < 600; cyc++) begin
      nrst = ($urandom_range(0, 49) != 0);
      valid5 = ($urandom_range(0, 9) < 7);
      stall_mem = ($urandom_range(0, 3) == 0);
      we5 = 1'($urandom);
      rd5 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      result5 = $urandom; pc5 = $urandom;
      csr_we5 = 1'($urandom); csr_addr5 = 12'($urandom); csr_wdata5 = $urandom;
      instruction_addr_misaligned5 = ($urandom_range(0, 15) == 0);
      illegal_instr5 = ($urandom_range(0, 15) == 0);
      ecall5 = ($urandom_range(0, 15) == 0);
      ebreak5 = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 23);
      mret5 = (r == 0); sret5 = (r == 1); uret5 = (r == 2);
      r = $urandom_range(0, 2);
      current_mode = (r == 2) ? 2'd3 : 2'(r);
      m_timer = ($urandom_range(0, 11) == 0); s_timer = ($urandom_range(0, 11) == 0);
      u_timer = ($urandom_range(0, 11) == 0);
      m_tie = 1'($urandom); s_tie = 1'($urandom); u_tie = 1'($urandom);
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h required %h", cyc, act_vec(), exp_vec());
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_illegal_flush();
    test_ecall_modes();
    test_irq_vs_mret();
    test_stall();
    test_reset_in_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
